// File: rtl/rover_display_scheduler_pkg.sv
// Shared types and widths for the rover display scheduler.
package rover_display_scheduler_pkg;
   typedef enum logic {ACCEPT = 1'b0, COMMIT = 1'b1} state_t;
   localparam int LOC_W            = 12;
   localparam int ORI_W            = 4;
   localparam int STALE_FRAMES_DEF = 60;
endpackage

// File: rtl/rover_display_scheduler_update_slot.sv
// One producer slot: req/ack capture into a pending register, cleared at frame commit.
module rover_display_scheduler_update_slot #(
   parameter int W = 12
) (
   input  logic         vclock,
   input  logic         reset,
   input  logic         open,
   input  logic         req,
   input  logic [W-1:0] data,
   input  logic         clear,
   output logic         ack,
   output logic [W-1:0] pend_data,
   output logic         pend_flag,
   output logic         overwrite
);
   logic capture;

   // ack blocks the very next edge, so a held req is recaptured every other cycle
   assign capture   = open & req & ~ack;
   assign overwrite = capture & pend_flag;

   always_ff @(posedge vclock or posedge reset) begin
      if (reset) begin
         ack       <= 1'b0;
         pend_data <= '0;
         pend_flag <= 1'b0;
      end else begin
         ack <= capture;
         if (capture) begin
            pend_data <= data;
            pend_flag <= 1'b1;
         end else if (clear) begin
            pend_flag <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/rover_display_scheduler.sv
// Frame-synchronous commit of location/orientation updates at the vsync falling edge.
module rover_display_scheduler
   import rover_display_scheduler_pkg::*;
#(
   parameter int STALE_FRAMES = STALE_FRAMES_DEF,
   parameter int DROP_W       = 8
) (
   input  logic              vclock,
   input  logic              reset,
   input  logic              vsync,
   input  logic              loc_req,
   input  logic [LOC_W-1:0]  loc_data,
   output logic              loc_ack,
   input  logic              ori_req,
   input  logic [ORI_W-1:0]  ori_data,
   output logic              ori_ack,
   output logic [LOC_W-1:0]  disp_location,
   output logic [ORI_W-1:0]  disp_orientation,
   output logic              disp_loc_valid,
   output logic              disp_ori_valid,
   output logic              frame_commit,
   output logic [DROP_W-1:0] drop_count
);
   localparam int SW = $clog2(STALE_FRAMES + 1);

   state_t             state;
   logic               vsync_q;
   logic               vs_fall;
   logic               in_accept;
   logic               in_commit;
   logic [LOC_W-1:0]   pend_loc;
   logic [ORI_W-1:0]   pend_ori;
   logic               loc_pend;
   logic               ori_pend;
   logic               loc_ow;
   logic               ori_ow;
   logic [SW-1:0]      stale_cnt;

   function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                 input logic [1:0] inc);
      logic [DROP_W:0] sum;
      sum = {1'b0, a} + {{(DROP_W-1){1'b0}}, inc};
      if (sum[DROP_W]) return '1;
      return sum[DROP_W-1:0];
   endfunction

   assign vs_fall   = vsync_q & ~vsync;
   assign in_accept = (state == ACCEPT);
   assign in_commit = (state == COMMIT);

   rover_display_scheduler_update_slot #(.W(LOC_W)) u_loc_slot (
      .vclock(vclock), .reset(reset), .open(in_accept), .req(loc_req),
      .data(loc_data), .clear(in_commit), .ack(loc_ack),
      .pend_data(pend_loc), .pend_flag(loc_pend), .overwrite(loc_ow)
   );

   rover_display_scheduler_update_slot #(.W(ORI_W)) u_ori_slot (
      .vclock(vclock), .reset(reset), .open(in_accept), .req(ori_req),
      .data(ori_data), .clear(in_commit), .ack(ori_ack),
      .pend_data(pend_ori), .pend_flag(ori_pend), .overwrite(ori_ow)
   );

   always_ff @(posedge vclock or posedge reset) begin
      if (reset) begin
         state            <= ACCEPT;
         vsync_q          <= 1'b1;
         stale_cnt        <= '0;
         frame_commit     <= 1'b0;
         drop_count       <= '0;
         disp_location    <= '0;
         disp_orientation <= '0;
         disp_loc_valid   <= 1'b0;
         disp_ori_valid   <= 1'b0;
      end else begin
         vsync_q      <= vsync;
         frame_commit <= 1'b0;
         drop_count   <= sat_add(drop_count, {1'b0, loc_ow} + {1'b0, ori_ow});
         case (state)
            ACCEPT: if (vs_fall) state <= COMMIT;
            COMMIT: begin
               state        <= ACCEPT;
               frame_commit <= 1'b1;
               if (loc_pend) begin
                  disp_location  <= pend_loc;
                  disp_loc_valid <= 1'b1;
                  stale_cnt      <= '0;
                  if (!ori_pend) disp_ori_valid <= 1'b0;
               end
               if (ori_pend) begin
                  disp_orientation <= pend_ori;
                  disp_ori_valid   <= 1'b1;
               end
               // Stale retirement wins over an orientation-only commit
               if (!loc_pend && stale_cnt != SW'(STALE_FRAMES)) begin
                  stale_cnt <= stale_cnt + 1'b1;
                  if (stale_cnt == SW'(STALE_FRAMES - 1)) begin
                     disp_loc_valid <= 1'b0;
                     disp_ori_valid <= 1'b0;
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: doc/rover_display_scheduler.md
Name: rover_display_scheduler

Overview:
Arbitrates and frame-synchronises rover display updates ahead of the VGA pixel datapath. Two producers post updates through a req/ack handshake: the ultrasound locator sends location (r,theta), and the orientation finder sends orientation. Posted updates are held as pending and committed atomically once per frame, at the falling edge of vsync. The datapath therefore never sees a location/orientation pair that changes mid-frame. The block also retires a stale rover after a run of frames with no location update.

Parameters:
STALE_FRAMES, 60, number of consecutive commits without a location update before disp_loc_valid drops (1 s at 60 Hz).
DROP_W, 8, width of the saturating overwrite counter.

Ports:
vclock  in  1  65 MHz pixel clock; the only clock.
reset  in  1  asynchronous, active-high.
vsync  in  1  XVGA vertical sync, active low, generated in the vclock domain.
loc_req  in  1  location update request.
loc_data  in  12  location {r,theta}.
loc_ack  out  1  one-cycle capture acknowledge for location.
ori_req  in  1  orientation update request.
ori_data  in  4  orientation code.
ori_ack  out  1  one-cycle capture acknowledge for orientation.
disp_location  out  12  committed location.
disp_orientation  out  4  committed orientation.
disp_loc_valid  out  1  committed location is fresh.
disp_ori_valid  out  1  committed orientation belongs to the committed location.
frame_commit  out  1  one-cycle pulse on each commit.
drop_count  out  DROP_W  saturating count of pending updates overwritten before commit.

Behaviour:
- Reset (asynchronous, takes effect immediately): state=ACCEPT, vsync_q=1, both pending flags 0, both pending data 0, stale_cnt 0. All outputs go to 0: disp_*, both valids, both acks, frame_commit, drop_count.
- vsync edge detection: vsync_q <= vsync each cycle; vs_fall = vsync_q & ~vsync. No synchroniser is used because vsync is already in the vclock domain.
- States:
  - ACCEPT: normal running state. On vs_fall, go to COMMIT.
  - COMMIT: lasts exactly 1 cycle, then returns to ACCEPT unconditionally.
- Capture, per source, evaluated independently:
  - Condition: state==ACCEPT, req==1, ack==0.
  - On that edge: pend_data <= data, pend_flag <= 1, ack <= 1.
  - ack is always cleared on the following edge.
  - A req held high is recaptured every 2 cycles. Requesters must drop req in the ack cycle.
- Overwrite: if pend_flag is already 1 at capture, the new data replaces the old and drop_count increments, saturating at all-ones. If both sources overwrite on the same edge, drop_count increments by 2, still saturating.
- Simultaneous requests from both sources are both captured on the same edge; there is no priority between them.
- Requests are not acked while in COMMIT. They stay pending at the requester and are acked in the next ACCEPT cycle, so they belong to the next frame.
- vs_fall in the same cycle as a capture: the capture completes in ACCEPT and the commit happens on the next edge, so the just-captured data IS committed.
- COMMIT actions, all registered on the same edge:
  - frame_commit <= 1 for that cycle.
  - If loc pend_flag: disp_location <= pend_loc, disp_loc_valid <= 1, stale_cnt <= 0. If no orientation is pending in the same commit, disp_ori_valid <= 0.
  - If ori pend_flag: disp_orientation <= pend_ori, disp_ori_valid <= 1.
  - If no location is pending: stale_cnt increments, saturating at STALE_FRAMES. When stale_cnt reaches STALE_FRAMES-1 → STALE_FRAMES, disp_loc_valid <= 0 and disp_ori_valid <= 0.
  - Both pend_flags are cleared.
- A commit with nothing pending leaves disp_location and disp_orientation unchanged.
- Latency: from the ack edge to display is the next vs_fall plus 1 cycle.
- Outputs are registered only; there are no combinational paths from the request inputs to the outputs.

Decomposition:
- Shared package: state encoding (ACCEPT, COMMIT), the 12-bit location width, the 4-bit orientation width, and the STALE_FRAMES default.
- One sub-module, update_slot, instantiated twice with parameter W (12 and 4). It owns the req/ack capture, the pending register/flag, a clear input, and a 1-bit overwrite strobe.
- The top level contains the FSM, the vsync edge detector, the stale counter and the display registers.

Test Plan:
- Reset mid-frame with loc pending 12'hA5C: assert reset asynchronously between clock edges → all outputs read 0 immediately; the next commit does not update disp_location.
- loc_req with 12'h3F1, then a vsync fall → loc_ack pulses once; frame_commit one cycle after vs_fall; disp_location=12'h3F1, disp_loc_valid=1, disp_ori_valid=0.
- loc 12'h120 and ori 4'h6 requested on the same cycle → both acks on the same edge; after commit, disp_location=12'h120, disp_orientation=4'h6, both valids 1; drop_count=0.
- Three location captures (12'h001, 12'h002, 12'h003) before one vs_fall → disp_location=12'h003, drop_count=2.
- ori_req raised in the COMMIT cycle → no ori_ack until the next cycle; the value appears only after the following frame's commit.
- STALE_FRAMES=3, one location commit, then 3 empty commits → disp_loc_valid stays 1 after empty commits 1 and 2 and drops to 0 on the 3rd; a new location restores it to 1.
